ex_div_ctrl: RTL and testbench

- Multi-cycle divide sequencer beside the EX stage.
- Accepts DIV/DIVU requests from EX and runs a 32-iteration radix-2 restoring divide.
- Holds the pipeline through stallreq_o and returns {remainder, quotient} for the HI/LO writeback path.
- Owns the iteration counter, the FSM, sign pre/post-correction and annul (flush) handling.

---
 rtl/ex_div_ctrl.sv | 97 +++++++++
 tb/tb_ex_div_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle radix-2 restoring divide sequencer for the EX stage.
// Returns {remainder, quotient} and stalls the pipeline while a divide is running.
module ex_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);
    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   div_q, a_abs, b_abs, quot, rem;
    logic [WIDTH:0]     trial;
    logic               qneg_q, rneg_q, go;

    always_comb begin
        go     = start_i & ~annul_i;
        a_abs  = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_abs  = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // a negative trial (top bit set) means the divisor did not fit: restore by shifting only
        trial  = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, div_q};
        work_d = trial[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        quot   = qneg_q ? -work_d[WIDTH-1:0] : work_d[WIDTH-1:0];
        rem    = rneg_q ? -work_d[2*WIDTH-1:WIDTH] : work_d[2*WIDTH-1:WIDTH];
    end

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            div_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (go) begin
                        state_q <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                        cnt_q   <= '0;
                        work_q  <= {{WIDTH{1'b0}}, a_abs};
                        div_q   <= b_abs;
                        rneg_q  <= signed_div_i & opdata1_i[WIDTH-1];
                        qneg_q  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    end
                end
                S_BYZERO: begin
                    if (!go) begin
                        state_q <= S_FREE;
                    end else begin
                        state_q  <= S_END;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                    end
                end
                S_ON: begin
                    if (!go) begin
                        state_q <= S_FREE;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH-1)) begin
                            state_q  <= S_END;
                            ready_o  <= 1'b1;
                            result_o <= {rem, quot};
                        end
                    end
                end
                default: begin
                    if (!go) begin
                        state_q  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed-vector bench for the divide sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ex_div_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        start = 1'b0, annul = 1'b0;
    logic [63:0] result;
    logic        ready, stallreq;
    int          tests = 0, fails = 0;

    ex_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div),
        .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts a divide at the next falling edge (cycle 0) and leaves start held once ready.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int n = 0;
        int gaps = 0;
        @(negedge clk);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        #1 chk({tag, "_stall0"}, 64'(stallreq), 64'd1);
        do begin
            @(negedge clk);
            n++;
            if (!ready && !stallreq) gaps++;
            if (n == 1) begin
                op1 = ~a;
                op2 = b ^ 32'h0000_0F0F;
            end
        end while (!ready && n < 40);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_stall_rdy"}, 64'(stallreq), 64'd0);
        chk({tag, "_stall_gaps"}, 64'(gaps), 64'd0);
    endtask

    task automatic release_chk(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_rel_rdy"}, 64'(ready), 64'd0);
        chk({tag, "_rel_res"}, result, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        #12;
        chk("rst_res", result, 64'd0);
        chk("rst_rdy", 64'(ready), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        release_chk("divu_100_7");
        run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        release_chk("div_m100_7");
        run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 33, {32'd2, 32'hFFFF_FFF2});
        release_chk("div_100_m7");
        run_div("div_zero", 1'b0, 32'd1234, 32'd0, 2, 64'd0);
        release_chk("div_zero");

        // annul at cycle 10, then a fresh request at cycle 12
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            chk($sformatf("annul_rdy%0d", n), 64'(ready), 64'd0);
            if (n == 10) begin
                annul = 1'b1;
                #1 chk("annul_stall", 64'(stallreq), 64'd0);
            end
            if (n == 11) begin
                annul = 1'b0;
                start = 1'b0;
            end
        end
        run_div("after_annul", 1'b0, 32'hFFFF_FFFF, 32'd3, 33, {32'd0, 32'h5555_5555});
        release_chk("after_annul");

        // asynchronous reset mid-operation
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_mid_rdy", 64'(ready), 64'd0);
        chk("rst_mid_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        run_div("after_rst", 1'b0, 32'd9, 32'd2, 33, {32'd1, 32'd4});
        release_chk("after_rst");

        // signed overflow, then hold start for 5 extra cycles
        run_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_rdy%0d", k), 64'(ready), 64'd1);
            chk($sformatf("hold_res%0d", k), result, {32'd0, 32'h8000_0000});
        end
        release_chk("ovf");

        // annul while the result is being presented
        run_div("end_annul", 1'b0, 32'd50, 32'd6, 33, {32'd2, 32'd8});
        @(negedge clk);
        annul = 1'b1;
        #1 chk("end_annul_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        chk("end_annul_rdy", 64'(ready), 64'd0);
        chk("end_annul_res", result, 64'd0);
        annul = 1'b0; start = 1'b0;

        // asynchronous reset while the result is valid
        run_div("end_rst", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 33, {32'hFFFF_FFFE, 32'd2});
        #2 rst = 1'b0;
        #1 chk("end_rst_rdy", 64'(ready), 64'd0);
        chk("end_rst_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
